alu_flags_pipe: RTL and testbench

ALU_FLAGS_PIPE -- requirements
Module: alu_flags_pipe

---
 rtl/alu_flags_pipe_pkg.sv | 18 +
 rtl/or_reduce_stage.sv | 32 +++
 rtl/alu_flags_pipe.sv | 130 +++++++++++++
 tb/tb_alu_flags_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_flags_pipe_pkg.sv
// Shared gate helpers and pipeline-depth arithmetic for the flag pipeline.
// The OR/NOT helpers keep the zero-detect tree built from explicit two-input gates.
package alu_flags_pipe_pkg;

    function automatic logic or2(input logic a, input logic b);
        return a | b;
    endfunction

    function automatic logic not1(input logic a);
        return ~a;
    endfunction

    // Number of register stages needed to cover log_w OR levels, lvls levels per stage.
    function automatic int stages_f(input int log_w, input int lvls);
        return (log_w + lvls - 1) / lvls;
    endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// Stateless slice of the zero-detect tree: ORs adjacent bit pairs for LVLS levels,
// shrinking IN_W bits to IN_W >> LVLS bits.
module or_reduce_stage
    import alu_flags_pipe_pkg::*;
#(
    parameter int IN_W = 4,
    parameter int LVLS = 2,
    localparam int OUT_W = IN_W >> LVLS
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        localparam int N = IN_W >> (l + 1);
        logic [2*N-1:0] src;
        logic [N-1:0]   v;

        if (l == 0) begin : g_first
            assign src = din;
        end else begin : g_next
            assign src = g_lvl[l-1].v;
        end

        for (genvar i = 0; i < N; i++) begin : g_gate
            assign v[i] = or2(src[2*i], src[2*i+1]);
        end
    end

    assign dout = g_lvl[LVLS-1].v;

endmodule

// File: rtl/alu_flags_pipe.sv
// Pipelined ALU flag generator: zero detect through a registered OR tree, with
// valid/sign/carry/overflow carried alongside in lockstep, plus a sticky overflow.
module alu_flags_pipe
    import alu_flags_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LVLS  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] result,
    input  logic             carryout,
    input  logic             overflow_in,
    input  logic             clear_sticky,
    output logic             valid_out,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             overflow_sticky
);

    localparam int LOG_W  = $clog2(WIDTH);
    localparam int STAGES = stages_f(LOG_W, LVLS);

    // Stage s holds the partially reduced word; its combinational tree slice feeds stage s+1,
    // and the last slice feeds the output flag registers directly.
    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int IN_W  = WIDTH >> (s * LVLS);
        localparam int NL    = (LOG_W - s * LVLS < LVLS) ? (LOG_W - s * LVLS) : LVLS;
        localparam int OUT_W = IN_W >> NL;

        logic [IN_W-1:0]  word_d;
        logic [IN_W-1:0]  word_q;
        logic [OUT_W-1:0] red;

        if (s == 0) begin : g_head
            always_comb word_d = result;
        end else begin : g_body
            always_comb word_d = g_stg[s-1].red;
        end

        or_reduce_stage #(.IN_W(IN_W), .LVLS(NL)) u_red (
            .din  (word_q),
            .dout (red)
        );

        always_ff @(posedge clk) begin
            if (reset) word_q <= '0;
            else       word_q <= word_d;
        end
    end

    logic [STAGES-1:0] vld_d, vld_q, neg_d, neg_q, cy_d, cy_q, ov_d, ov_q;
    logic valid_out_d, valid_out_q, zero_d, zero_q, negative_d, negative_q;
    logic carry_d, carry_q, overflow_d, overflow_q, sticky_d, sticky_q;
    logic last_vld;

    assign last_vld = vld_q[STAGES-1];

    always_comb begin
        vld_d    = '0;
        neg_d    = '0;
        cy_d     = '0;
        ov_d     = '0;
        vld_d[0] = valid_in;
        neg_d[0] = result[WIDTH-1];
        cy_d[0]  = carryout;
        ov_d[0]  = overflow_in;
        for (int s = 1; s < STAGES; s++) begin
            vld_d[s] = vld_q[s-1];
            neg_d[s] = neg_q[s-1];
            cy_d[s]  = cy_q[s-1];
            ov_d[s]  = ov_q[s-1];
        end
    end

    always_comb begin
        valid_out_d = last_vld;
        zero_d      = zero_q;
        negative_d  = negative_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        sticky_d    = sticky_q;
        if (last_vld) begin
            zero_d     = not1(g_stg[STAGES-1].red[0]);
            negative_d = neg_q[STAGES-1];
            carry_d    = cy_q[STAGES-1];
            overflow_d = ov_q[STAGES-1];
        end
        if (clear_sticky) sticky_d = 1'b0;
        // A set arriving on the same edge as a clear must win.
        if (last_vld && ov_q[STAGES-1]) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            neg_q       <= '0;
            cy_q        <= '0;
            ov_q        <= '0;
            valid_out_q <= 1'b0;
            zero_q      <= 1'b1;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            neg_q       <= neg_d;
            cy_q        <= cy_d;
            ov_q        <= ov_d;
            valid_out_q <= valid_out_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            sticky_q    <= sticky_d;
        end
    end

    assign valid_out       = valid_out_q;
    assign zero            = zero_q;
    assign negative        = negative_q;
    assign carry           = carry_q;
    assign overflow        = overflow_q;
    assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_alu_flags_pipe.sv
// Directed bench for alu_flags_pipe: default 32/2 instance plus 8/1 and 64/4 sweep instances.
module tb_alu_flags_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        a_vin = 0, a_co = 0, a_ovi = 0, a_clr = 0;
    logic [31:0] a_res = '0;
    logic        a_vout, a_zero, a_neg, a_carry, a_ovf, a_sticky;

    logic        b_vin = 0;
    logic [7:0]  b_res = '0;
    logic        b_vout, b_zero, b_neg, b_carry, b_ovf, b_sticky;

    logic        c_vin = 0;
    logic [63:0] c_res = '0;
    logic        c_vout, c_zero, c_neg, c_carry, c_ovf, c_sticky;

    logic        tie0 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    alu_flags_pipe u_a (
        .clk(clk), .reset(rst), .valid_in(a_vin), .result(a_res), .carryout(a_co),
        .overflow_in(a_ovi), .clear_sticky(a_clr), .valid_out(a_vout), .zero(a_zero),
        .negative(a_neg), .carry(a_carry), .overflow(a_ovf), .overflow_sticky(a_sticky)
    );

    alu_flags_pipe #(.WIDTH(8), .LVLS(1)) u_b (
        .clk(clk), .reset(rst), .valid_in(b_vin), .result(b_res), .carryout(tie0),
        .overflow_in(tie0), .clear_sticky(tie0), .valid_out(b_vout), .zero(b_zero),
        .negative(b_neg), .carry(b_carry), .overflow(b_ovf), .overflow_sticky(b_sticky)
    );

    alu_flags_pipe #(.WIDTH(64), .LVLS(4)) u_c (
        .clk(clk), .reset(rst), .valid_in(c_vin), .result(c_res), .carryout(tie0),
        .overflow_in(tie0), .clear_sticky(tie0), .valid_out(c_vout), .zero(c_zero),
        .negative(c_neg), .carry(c_carry), .overflow(c_ovf), .overflow_sticky(c_sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        do_reset();
        got = {a_vout, a_zero, a_neg, a_carry, a_ovf, a_sticky};
        n_tests++;
        if (got !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_a got %b exp 010000", got);
        end
        n_tests++;
        if ({b_vout, b_zero, c_vout, c_zero} !== 4'b0101) begin
            n_fail++;
            $display("FAIL reset_bc got %b exp 0101", {b_vout, b_zero, c_vout, c_zero});
        end
    endtask

    task automatic test_zero_latency();
        a_vin = 1; a_res = 32'h0000_0000; a_co = 1;
        tick();
        a_vin = 0; a_co = 0; a_res = 32'hdead_beef;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_tests++;
            if (a_vout !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_early_vout cycle %0d got %b exp 0", k, a_vout);
            end
        end
        tick();
        n_tests++;
        if ({a_vout, a_zero, a_neg, a_carry} !== 4'b1101) begin
            n_fail++;
            $display("FAIL zero_item got %b exp 1101", {a_vout, a_zero, a_neg, a_carry});
        end
        tick();
        n_tests++;
        if ({a_vout, a_zero, a_carry} !== 3'b011) begin
            n_fail++;
            $display("FAIL zero_hold got %b exp 011", {a_vout, a_zero, a_carry});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [3];
        logic [2:0]  exp [3];
        vec[0] = 32'h8000_0000; exp[0] = 3'b101;
        vec[1] = 32'h0000_0001; exp[1] = 3'b100;
        vec[2] = 32'h0000_0000; exp[2] = 3'b110;
        for (int i = 0; i < 3; i++) begin
            a_vin = 1; a_res = vec[i];
            tick();
        end
        a_vin = 0; a_res = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({a_vout, a_zero, a_neg} !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_item%0d got %b exp %b", i, {a_vout, a_zero, a_neg}, exp[i]);
            end
        end
        tick();
        n_tests++;
        if (a_vout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end_vout got %b exp 0", a_vout);
        end
    endtask

    task automatic test_sticky();
        do_reset();
        a_vin = 1; a_ovi = 1; a_res = 32'h1;
        tick();
        a_vin = 0; a_ovi = 0;
        tick(); tick(); tick();
        n_tests++;
        if ({a_vout, a_ovf, a_sticky} !== 3'b111) begin
            n_fail++;
            $display("FAIL sticky_set got %b exp 111", {a_vout, a_ovf, a_sticky});
        end
        a_vin = 1; a_ovi = 1;
        tick();
        a_vin = 0; a_ovi = 0;
        tick(); tick();
        a_clr = 1;
        tick();
        a_clr = 0;
        n_tests++;
        if ({a_vout, a_ovf, a_sticky} !== 3'b111) begin
            n_fail++;
            $display("FAIL sticky_set_wins got %b exp 111", {a_vout, a_ovf, a_sticky});
        end
        a_clr = 1;
        tick();
        a_clr = 0;
        n_tests++;
        if ({a_vout, a_ovf, a_sticky} !== 3'b010) begin
            n_fail++;
            $display("FAIL sticky_clear got %b exp 010", {a_vout, a_ovf, a_sticky});
        end
    endtask

    task automatic test_reset_flight();
        logic [5:0] got;
        a_vin = 1; a_res = 32'h5; a_co = 1; a_ovi = 1;
        tick();
        a_res = 32'h8000_0000;
        tick();
        rst = 1;
        a_res = 32'h0;
        tick();
        rst = 0;
        a_vin = 0; a_co = 0; a_ovi = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            got = {a_vout, a_zero, a_neg, a_carry, a_ovf, a_sticky};
            n_tests++;
            if (got !== 6'b010000) begin
                n_fail++;
                $display("FAIL flight_discard cycle %0d got %b exp 010000", k, got);
            end
        end
    endtask

    task automatic test_idle();
        a_vin = 1; a_res = 32'h0000_0010;
        tick();
        a_vin = 0; a_res = '0;
        tick(); tick(); tick();
        n_tests++;
        if ({a_vout, a_zero} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_item got %b exp 10", {a_vout, a_zero});
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if ({a_vout, a_zero} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_hold cycle %0d got %b exp 00", k, {a_vout, a_zero});
            end
        end
    endtask

    task automatic test_sweep();
        for (int p = 0; p < 8; p++) begin
            b_vin = 1; b_res = 8'd1 << p;
            tick();
            b_vin = 0; b_res = '0;
            tick(); tick();
            n_tests++;
            if (b_vout !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep8_early pos %0d got %b exp 0", p, b_vout);
            end
            tick();
            n_tests++;
            if ({b_vout, b_zero, b_neg} !== {2'b10, p == 7}) begin
                n_fail++;
                $display("FAIL sweep8 pos %0d got %b exp %b", p, {b_vout, b_zero, b_neg}, {2'b10, p == 7});
            end
        end
        for (int p = 0; p < 64; p++) begin
            c_vin = 1; c_res = 64'd1 << p;
            tick();
            c_vin = 0; c_res = '0;
            tick();
            n_tests++;
            if (c_vout !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep64_early pos %0d got %b exp 0", p, c_vout);
            end
            tick();
            n_tests++;
            if ({c_vout, c_zero, c_neg} !== {2'b10, p == 63}) begin
                n_fail++;
                $display("FAIL sweep64 pos %0d got %b exp %b", p, {c_vout, c_zero, c_neg}, {2'b10, p == 63});
            end
        end
        b_vin = 1; b_res = 8'h00;
        tick();
        b_vin = 0;
        tick(); tick(); tick();
        n_tests++;
        if ({b_vout, b_zero} !== 2'b11) begin
            n_fail++;
            $display("FAIL sweep8_zero got %b exp 11", {b_vout, b_zero});
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_back_to_back();
        test_sticky();
        test_reset_flight();
        test_idle();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
